// File: rtl/score_display_ctrl_pkg.sv
// Shared types and constants for the score display controller.
// FSM state encoding, digit codes and the input saturation helper.
package score_display_ctrl_pkg;

   typedef enum logic [1:0] {
      StBlank,
      StConv,
      StShow,
      StFlash
   } state_e;

   localparam logic [3:0] BLANK_CODE = 4'hB;
   localparam logic [6:0] MAX_SCORE  = 7'd99;

   function automatic logic [6:0] sat_score(input logic [6:0] v);
      return (v > MAX_SCORE) ? MAX_SCORE : v;
   endfunction

endpackage

// File: rtl/bcd_iter.sv
// Binary-to-BCD for 0..99 by repeated subtraction of 10, one step per cycle.
// done is high once the remainder has dropped below 10.
module bcd_iter (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [6:0] value,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       done
);

   logic [6:0] rem_q;
   logic [3:0] tens_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         tens_q <= '0;
      end else if (load) begin
         rem_q  <= value;
         tens_q <= '0;
      end else if (rem_q >= 7'd10) begin
         rem_q  <= rem_q - 7'd10;
         tens_q <= tens_q + 4'd1;
      end
   end

   assign done = (rem_q < 7'd10);
   assign tens = tens_q;
   assign ones = rem_q[3:0];

endmodule

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every SCAN_DIV clocks,
// first tick SCAN_DIV clocks after the last reset edge.
module tick_gen #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CntW = $clog2(SCAN_DIV);

   logic [CntW-1:0] cnt_q;
   logic            tick_q;
   logic            wrap;

   assign wrap = (cnt_q == CntW'(SCAN_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= wrap;
         if (wrap) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CntW'(1);
         end
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/score_display_ctrl.sv
// Two-player score display controller: BCD conversion, display hold and winner flash.
// Optional LEADING_ZERO_BLANK_EN: a tens digit of 0 is committed as the blank code.
module score_display_ctrl
   import score_display_ctrl_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 100000,
   parameter int unsigned FLASH_TICKS  = 64,
   parameter int unsigned FLASH_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] score_a,
   input  logic [6:0] score_b,
   input  logic       win_req,
   input  logic       win_player,
   output logic       scan_tick,
   output logic [3:0] num1,
   output logic [3:0] num2,
   output logic [3:0] num3,
   output logic [3:0] num4,
   output logic       busy
);

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LzBlank = 1'b1;
`else
   localparam bit LzBlank = 1'b0;
`endif

   function automatic logic [3:0] tens_code(input logic [3:0] t);
      return (LzBlank && (t == 4'd0)) ? BLANK_CODE : t;
   endfunction

   state_e     state_q, state_d;
   logic       tick;
   logic [6:0] sat_a, sat_b;
   logic [6:0] lat_a_q, lat_b_q;
   logic       load, commit, flash_start;
   logic       win_now, win_pl_now;
   logic       pend_q, pend_pl_q, winner_q;
   logic [9:0] ftick_q;
   logic [3:0] pair_q;
   logic       phase_q;  // 0 = winner digits blanked, 1 = winner digits shown
   logic       flash_end;
   logic [3:0] tens_a, ones_a, tens_b, ones_b;
   logic       done_a, done_b;
   logic [3:0] num1_q, num2_q, num3_q, num4_q;

   tick_gen #(
      .SCAN_DIV (SCAN_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   bcd_iter u_bcd_a (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .value (sat_a),
      .tens  (tens_a),
      .ones  (ones_a),
      .done  (done_a)
   );

   bcd_iter u_bcd_b (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .value (sat_b),
      .tens  (tens_b),
      .ones  (ones_b),
      .done  (done_b)
   );

   assign sat_a      = sat_score(score_a);
   assign sat_b      = sat_score(score_b);
   assign win_now    = pend_q | win_req;
   assign win_pl_now = win_req ? win_player : pend_pl_q;
   assign flash_end  = tick && (ftick_q == 10'(FLASH_TICKS - 1)) && phase_q &&
                       (pair_q == 4'(FLASH_CYCLES - 1));

   always_comb begin
      state_d     = state_q;
      load        = 1'b0;
      commit      = 1'b0;
      flash_start = 1'b0;
      unique case (state_q)
         StBlank: begin
            if (tick) begin
               state_d = StConv;
               load    = 1'b1;
            end
         end
         StConv: begin
            if (done_a && done_b) begin
               commit = 1'b1;
               if (win_now) begin
                  state_d     = StFlash;
                  flash_start = 1'b1;
               end else begin
                  state_d = StShow;
               end
            end
         end
         StShow: begin
            // A win request takes priority over a coincident score check.
            if (win_req) begin
               state_d     = StFlash;
               flash_start = 1'b1;
            end else if (tick && ((sat_a != lat_a_q) || (sat_b != lat_b_q))) begin
               state_d = StConv;
               load    = 1'b1;
            end
         end
         StFlash: begin
            if (flash_end) begin
               state_d = StConv;
               load    = 1'b1;
            end
         end
         default: state_d = StBlank;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StBlank;
         lat_a_q   <= '0;
         lat_b_q   <= '0;
         pend_q    <= 1'b0;
         pend_pl_q <= 1'b0;
         winner_q  <= 1'b0;
         ftick_q   <= '0;
         pair_q    <= '0;
         phase_q   <= 1'b0;
         num1_q    <= BLANK_CODE;
         num2_q    <= BLANK_CODE;
         num3_q    <= BLANK_CODE;
         num4_q    <= BLANK_CODE;
      end else begin
         state_q <= state_d;
         if (load) begin
            lat_a_q <= sat_a;
            lat_b_q <= sat_b;
         end
         if (commit) begin
            pend_q <= 1'b0;
            num1_q <= tens_code(tens_a);
            num2_q <= ones_a;
            num3_q <= tens_code(tens_b);
            num4_q <= ones_b;
         end else if ((state_q == StConv) && win_req) begin
            pend_q    <= 1'b1;
            pend_pl_q <= win_player;
         end
         if (flash_start) begin
            winner_q <= win_pl_now;
            ftick_q  <= '0;
            pair_q   <= '0;
            phase_q  <= 1'b0;
         end else if ((state_q == StFlash) && tick) begin
            if (ftick_q == 10'(FLASH_TICKS - 1)) begin
               ftick_q <= '0;
               phase_q <= ~phase_q;
               if (phase_q) begin
                  pair_q <= pair_q + 4'd1;
               end
            end else begin
               ftick_q <= ftick_q + 10'd1;
            end
         end
      end
   end

   always_comb begin
      num1 = num1_q;
      num2 = num2_q;
      num3 = num3_q;
      num4 = num4_q;
      if ((state_q == StFlash) && !phase_q) begin
         if (winner_q) begin
            num3 = BLANK_CODE;
            num4 = BLANK_CODE;
         end else begin
            num1 = BLANK_CODE;
            num2 = BLANK_CODE;
         end
      end
   end

   assign scan_tick = tick;
   assign busy      = (state_q == StConv) || (state_q == StFlash);

endmodule

// File: tb/tb_score_display_ctrl.sv
// Randomised self-checking bench for score_display_ctrl against a digit-level model.
module tb_score_display_ctrl;

   localparam int SD = 16;
   localparam int FT = 2;
   localparam int FC = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] score_a = '0;
   logic [6:0] score_b = '0;
   logic       win_req = 1'b0;
   logic       win_player = 1'b0;
   logic       scan_tick, busy;
   logic [3:0] num1, num2, num3, num4;
   logic [15:0] nums;

   int vectors = 0;
   int miscompares = 0;
   int since_rst = 0;
   int lat_a = -1;
   int lat_b = -1;
   logic [15:0] exp_nums = 16'hBBBB;

   score_display_ctrl #(
      .SCAN_DIV     (SD),
      .FLASH_TICKS  (FT),
      .FLASH_CYCLES (FC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .score_a    (score_a),
      .score_b    (score_b),
      .win_req    (win_req),
      .win_player (win_player),
      .scan_tick  (scan_tick),
      .num1       (num1),
      .num2       (num2),
      .num3       (num3),
      .num4       (num4),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   assign nums = {num1, num2, num3, num4};

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   function automatic int satv(input int v);
      return (v > 99) ? 99 : v;
   endfunction

   function automatic logic [3:0] tcode(input int v);
      int t;
      t = satv(v) / 10;
`ifdef LEADING_ZERO_BLANK_EN
      if (t == 0) return 4'hB;
`endif
      return 4'(t);
   endfunction

   function automatic logic [15:0] digits(input int a, input int b);
      return {tcode(a), 4'(satv(a) % 10), tcode(b), 4'(satv(b) % 10)};
   endfunction

   function automatic bit tick_exp();
      return (since_rst > 0) && (since_rst % SD == 0);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      since_rst++;
   endtask

   // Returns on a sample where the model predicts scan_tick high.
   task automatic wait_tick();
      int n;
      n = 0;
      while (!tick_exp() && n <= SD + 1) begin
         step();
         n++;
         vectors++;
         if (scan_tick !== tick_exp()) begin
            miscompares++;
            $display("FAIL tick_period: scan_tick=%b required %b at cycle %0d",
                     scan_tick, tick_exp(), since_rst);
         end
      end
   endtask

   // Entered on the first CONV cycle; follows it to the commit.
   task automatic wait_conv(input int a, input int b);
      int n, exp_l;
      n = 0;
      exp_l = ((satv(a) / 10 > satv(b) / 10) ? satv(a) / 10 : satv(b) / 10) + 1;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL conv_busy: busy=%b required 1", busy);
      end
      while (busy === 1'b1 && n < 12) begin
         vectors++;
         if (nums !== exp_nums) begin
            miscompares++;
            $display("FAIL conv_hold: nums=%h required %h", nums, exp_nums);
         end
         step();
         n++;
      end
      lat_a = satv(a);
      lat_b = satv(b);
      exp_nums = digits(a, b);
      vectors++;
      if (busy !== 1'b0 || n != exp_l) begin
         miscompares++;
         $display("FAIL conv_latency: busy=%b after %0d cycles, required 0 after %0d",
                  busy, n, exp_l);
      end
      vectors++;
      if (nums !== exp_nums) begin
         miscompares++;
         $display("FAIL conv_digits: nums=%h required %h (a=%0d b=%0d)", nums, exp_nums, a, b);
      end
   endtask

   // Entered on the first FLASH cycle; returns on the first CONV cycle after it.
   task automatic run_flash(input bit w);
      int consumed, guard;
      bit t;
      logic [15:0] e;
      consumed = 0;
      guard = 0;
      while (consumed < 2 * FT * FC && guard < 2 * FT * FC * SD + SD + 4) begin
         e = exp_nums;
         if ((consumed / FT) % 2 == 0) begin
            if (w) e[7:0] = 8'hBB;
            else e[15:8] = 8'hBB;
         end
         vectors++;
         if (nums !== e || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL flash_digits: nums=%h busy=%b required %h busy=1 after %0d ticks",
                     nums, busy, e, consumed);
         end
         t = tick_exp();
         step();
         guard++;
         if (t) consumed++;
      end
      vectors++;
      if (consumed < 2 * FT * FC) begin
         miscompares++;
         $display("FAIL flash_timeout: %0d ticks consumed, required %0d", consumed, 2 * FT * FC);
      end
   endtask

   task automatic show_scores(input int a, input int b);
      bit changed;
      score_a = 7'(a);
      score_b = 7'(b);
      changed = (satv(a) != lat_a) || (satv(b) != lat_b);
      wait_tick();
      step();
      vectors++;
      if (busy !== changed) begin
         miscompares++;
         $display("FAIL show_recheck: busy=%b required %b", busy, changed);
      end
      if (changed) wait_conv(a, b);
      else begin
         vectors++;
         if (nums !== exp_nums) begin
            miscompares++;
            $display("FAIL show_hold: nums=%h required %h", nums, exp_nums);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      since_rst = 0;
      exp_nums = 16'hBBBB;
      vectors++;
      if (nums !== 16'hBBBB || busy !== 1'b0 || scan_tick !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: nums=%h busy=%b tick=%b required BBBB 0 0",
                  nums, busy, scan_tick);
      end
   endtask

   task automatic test_first_conv();
      for (int i = 1; i <= SD; i++) begin
         step();
         win_req = (i == 5);
         win_player = 1'b1;
         vectors++;
         if (nums !== 16'hBBBB || busy !== 1'b0 || scan_tick !== tick_exp()) begin
            miscompares++;
            $display("FAIL blank_phase: nums=%h busy=%b tick=%b required BBBB 0 %b at %0d",
                     nums, busy, scan_tick, tick_exp(), i);
         end
      end
      win_req = 1'b0;
      step();
      wait_conv(7, 42);
   endtask

   task automatic test_random();
      int a, b;
      for (int i = 0; i < 14; i++) begin
         a = (i == 0) ? 120 : int'($urandom_range(0, 127));
         b = ($urandom_range(0, 3) == 0) ? lat_b : int'($urandom_range(0, 127));
         if (i % 5 == 4) a = lat_a;
         show_scores(a, b);
      end
   endtask

   task automatic test_flash();
      if (tick_exp()) step();
      win_req = 1'b1;
      win_player = 1'b1;
      step();
      win_req = 1'b0;
      score_a = 7'((lat_a + 1 + int'($urandom_range(0, 50))) % 100);
      run_flash(1'b1);
      wait_conv(int'(score_a), int'(score_b));
   endtask

   task automatic test_pending_win();
      int a, l;
      a = 20 + int'($urandom_range(0, 79));
      if (a == lat_a) a = (a == 99) ? 20 : a + 1;
      score_a = 7'(a);
      l = ((a / 10 > lat_b / 10) ? a / 10 : lat_b / 10) + 1;
      wait_tick();
      step();
      win_req = 1'b1;
      win_player = 1'b0;
      step();
      win_req = 1'b0;
      for (int i = 2; i <= l; i++) begin
         vectors++;
         if (nums !== exp_nums || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pending_conv: nums=%h busy=%b required %h busy=1", nums, busy, exp_nums);
         end
         step();
      end
      lat_a = a;
      exp_nums = digits(a, lat_b);
      vectors++;
      if (nums !== {8'hBB, exp_nums[7:0]} || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL pending_flash: nums=%h busy=%b required %h busy=1",
                  nums, busy, {8'hBB, exp_nums[7:0]});
      end
      run_flash(1'b0);
      wait_conv(int'(score_a), int'(score_b));
   endtask

   task automatic test_win_tick();
      show_scores(3, int'(score_b));
      score_a = 7'd4;
      wait_tick();
      win_req = 1'b1;
      win_player = 1'b0;
      step();
      win_req = 1'b0;
      run_flash(1'b0);
      wait_conv(4, int'(score_b));
      vectors++;
      if (num2 !== 4'd4) begin
         miscompares++;
         $display("FAIL win_tick_final: num2=%h required 4", num2);
      end
   endtask

   task automatic test_reset_mid_conv();
      score_a = 7'd99;
      wait_tick();
      step();
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      since_rst = 0;
      exp_nums = 16'hBBBB;
      lat_a = -1;
      lat_b = -1;
      vectors++;
      if (nums !== 16'hBBBB || busy !== 1'b0 || scan_tick !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_conv: nums=%h busy=%b tick=%b required BBBB 0 0",
                  nums, busy, scan_tick);
      end
      for (int i = 1; i <= SD; i++) begin
         step();
         vectors++;
         if (scan_tick !== tick_exp() || nums !== 16'hBBBB || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tick: tick=%b nums=%h busy=%b required %b BBBB 0 at %0d",
                     scan_tick, nums, busy, tick_exp(), i);
         end
      end
      step();
      wait_conv(99, int'(score_b));
   endtask

   initial begin
      score_a = 7'd7;
      score_b = 7'd42;
      test_reset();
      test_first_conv();
      test_random();
      test_flash();
      test_pending_win();
      test_win_tick();
      test_reset_mid_conv();
      score_b = 7'd5;
      show_scores(int'(score_a), 5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
